// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage issue controller driving a combinational ALU.
// Decodes one instruction per handshake into registered ALU operands, captures
// the ALU result one cycle later and presents it with a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN (illegal instructions are
// zeroed and flagged on out_illegal; otherwise they execute as rs+rt).
`timescale 1ns/1ps
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_taken,
  output logic        out_illegal
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FUN_W  = 6;
  localparam int unsigned REG_W  = 5;

  localparam logic [FUN_W-1:0] FUN_ADD = 6'b000000;
  localparam logic [FUN_W-1:0] FUN_SUB = 6'b000001;
  localparam logic [FUN_W-1:0] FUN_AND = 6'b011000;
  localparam logic [FUN_W-1:0] FUN_OR  = 6'b011110;
  localparam logic [FUN_W-1:0] FUN_XOR = 6'b010110;
  localparam logic [FUN_W-1:0] FUN_NOR = 6'b010001;
  localparam logic [FUN_W-1:0] FUN_SLL = 6'b100000;
  localparam logic [FUN_W-1:0] FUN_SRL = 6'b100001;
  localparam logic [FUN_W-1:0] FUN_SRA = 6'b100011;
  localparam logic [FUN_W-1:0] FUN_EQ  = 6'b110011;
  localparam logic [FUN_W-1:0] FUN_NE  = 6'b110001;
  localparam logic [FUN_W-1:0] FUN_LT  = 6'b110101;
  localparam logic [FUN_W-1:0] FUN_LEZ = 6'b111101;
  localparam logic [FUN_W-1:0] FUN_GTZ = 6'b111111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;
  state_t state;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_W-1:0]  rt_f;
  logic [REG_W-1:0]  rd_f;
  logic [REG_W-1:0]  shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;

  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [FUN_W-1:0]  dec_fun;
  logic              dec_sign;
  logic [REG_W-1:0]  dec_rd;
  logic              dec_branch;
  logic              dec_illegal;

  logic [REG_W-1:0]  pend_rd;
  logic              pend_branch;
  logic              pend_illegal;
  logic              accept;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'b0, imm};

  // Ready in IDLE, or in HOLD when the pending result is being retired
  assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Instruction decode into ALU operands, function code and result routing
  always_comb begin
    dec_a       = rs_data;
    dec_b       = rt_data;
    dec_fun     = FUN_ADD;
    dec_sign    = 1'b1;
    dec_rd      = rd_f;
    dec_branch  = 1'b0;
    dec_illegal = 1'b1;
    unique case (opcode)
      6'h00: begin
        dec_illegal = 1'b0;
        unique case (funct)
          6'h20: dec_fun = FUN_ADD;
          6'h21: begin dec_fun = FUN_ADD; dec_sign = 1'b0; end
          6'h22: dec_fun = FUN_SUB;
          6'h23: begin dec_fun = FUN_SUB; dec_sign = 1'b0; end
          6'h24: dec_fun = FUN_AND;
          6'h25: dec_fun = FUN_OR;
          6'h26: dec_fun = FUN_XOR;
          6'h27: dec_fun = FUN_NOR;
          6'h2A: dec_fun = FUN_LT;
          6'h2B: begin dec_fun = FUN_LT; dec_sign = 1'b0; end
          6'h00: begin dec_fun = FUN_SLL; dec_a = DATA_W'(shamt); end
          6'h02: begin dec_fun = FUN_SRL; dec_a = DATA_W'(shamt); end
          6'h03: begin dec_fun = FUN_SRA; dec_a = DATA_W'(shamt); end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_sx; end
      6'h09: begin dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_sx; dec_sign = 1'b0; end
      6'h0A: begin dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_sx; dec_fun = FUN_LT; end
      6'h0B: begin
        dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_sx; dec_fun = FUN_LT; dec_sign = 1'b0;
      end
      6'h0C: begin dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_zx; dec_fun = FUN_AND; end
      6'h0D: begin dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_zx; dec_fun = FUN_OR; end
      6'h0F: begin
        dec_illegal = 1'b0; dec_rd = rt_f; dec_b = imm_zx; dec_fun = FUN_SLL;
        dec_a = DATA_W'(16);
      end
      6'h04: begin dec_illegal = 1'b0; dec_rd = '0; dec_branch = 1'b1; dec_fun = FUN_EQ; end
      6'h05: begin dec_illegal = 1'b0; dec_rd = '0; dec_branch = 1'b1; dec_fun = FUN_NE; end
      6'h06: begin
        dec_illegal = 1'b0; dec_rd = '0; dec_branch = 1'b1; dec_fun = FUN_LEZ; dec_b = '0;
      end
      6'h07: begin
        dec_illegal = 1'b0; dec_rd = '0; dec_branch = 1'b1; dec_fun = FUN_GTZ; dec_b = '0;
      end
      default: dec_illegal = 1'b1;
    endcase
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    // Trapped instructions compute 0+0 so the result and destination are clean
    if (dec_illegal) begin
      dec_a      = '0;
      dec_b      = '0;
      dec_fun    = FUN_ADD;
      dec_sign   = 1'b1;
      dec_rd     = '0;
      dec_branch = 1'b0;
    end
`else
    // Unknown encodings fall through to the default rs+rt add into rd
    dec_illegal = 1'b0;
`endif
  end

  // State machine, operand registers and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fun      <= '0;
      alu_sign     <= 1'b0;
      pend_rd      <= '0;
      pend_branch  <= 1'b0;
      pend_illegal <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_taken    <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a        <= dec_a;
        alu_b        <= dec_b;
        alu_fun      <= dec_fun;
        alu_sign     <= dec_sign;
        pend_rd      <= dec_rd;
        pend_branch  <= dec_branch;
        pend_illegal <= dec_illegal;
      end
      unique case (state)
        S_IDLE: if (in_valid) state <= S_EXEC;
        S_EXEC: begin
          out_result  <= alu_out;
          out_rd      <= pend_rd;
          out_taken   <= pend_branch && alu_out[0];
          out_illegal <= pend_illegal;
          out_valid   <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
